// File: rtl/dm_access_arbiter.sv
// Data-memory access arbiter: M0 (pipeline MEM stage) vs M1 (bulk-copy/DMA engine).
// Build option: define DM_ARB_ROUND_ROBIN_EN for alternating priority; default is fixed M0 priority.
module dm_access_arbiter #(
  parameter int DEPTH_WORDS = 3072,
  parameter int MAX_BURST   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_pc,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_err,
  output logic        m1_err,
  output logic        dm_wr,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata
);

  // Handshake: a master raises req with a stable payload and keeps both stable
  // until gnt is seen high in the same cycle; the transfer completes on that
  // clock edge and rvalid (with err/rdata) answers exactly one cycle later.

  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [7:0]  MAX_B      = 8'(MAX_BURST);

  logic       last_gnt;
  logic [7:0] burst_cnt;
  logic       m1_locked_q;
  logic       m0_legal;
  logic       m1_legal;
  logic       hold;
  logic       win_m0;
  logic       win_m1;

  assign m0_legal = (m0_addr[1:0] == 2'b00) && ({1'b0, m0_addr} < ADDR_LIMIT);
  assign m1_legal = (m1_addr[1:0] == 2'b00) && ({1'b0, m1_addr} < ADDR_LIMIT);

  // m1_locked_q means M1 won last cycle with m1_lock high.
  assign hold = last_gnt && m1_locked_q && m1_req &&
                ((burst_cnt < MAX_B) || !m0_req);

  always_comb begin
    win_m0 = 1'b0;
    win_m1 = 1'b0;
    if (reset) begin
      win_m0 = 1'b0;
      win_m1 = 1'b0;
    end else if (hold) begin
      win_m1 = 1'b1;
    end else if (m0_req && !m1_req) begin
      win_m0 = 1'b1;
    end else if (m1_req && !m0_req) begin
      win_m1 = 1'b1;
    end else if (m0_req && m1_req) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
      win_m0 = last_gnt;
      win_m1 = !last_gnt;
`else
      win_m0 = 1'b1;
`endif
    end
  end

  assign m0_gnt  = win_m0;
  assign m1_gnt  = win_m1;
  assign dm_addr = win_m1 ? m1_addr  : m0_addr;
  assign dm_wd   = win_m1 ? m1_wdata : m0_wdata;
  assign dm_pc   = win_m0 ? m0_pc    : 32'h0;
  assign dm_wr   = (win_m0 && m0_we && m0_legal) || (win_m1 && m1_we && m1_legal);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt    <= 1'b1;
      burst_cnt   <= 8'd0;
      m1_locked_q <= 1'b0;
      m0_rvalid   <= 1'b0;
      m1_rvalid   <= 1'b0;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
      m0_rdata    <= 32'h0;
      m1_rdata    <= 32'h0;
    end else begin
      m0_rvalid   <= win_m0;
      m1_rvalid   <= win_m1;
      m0_err      <= win_m0 && !m0_legal;
      m1_err      <= win_m1 && !m1_legal;
      m0_rdata    <= (win_m0 && !m0_we && m0_legal) ? dm_rdata : 32'h0;
      m1_rdata    <= (win_m1 && !m1_we && m1_legal) ? dm_rdata : 32'h0;
      m1_locked_q <= win_m1 && m1_lock;
      if (win_m1) begin
        if (m1_lock && (burst_cnt != 8'hFF)) burst_cnt <= burst_cnt + 8'd1;
      end else begin
        burst_cnt <= 8'd0;
      end
      if (win_m0)      last_gnt <= 1'b0;
      else if (win_m1) last_gnt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Self-checking bench for dm_access_arbiter: directed scenarios plus randomized
// traffic scored against a rule-level arbitration and memory model.
module tb_dm_access_arbiter;

  localparam int DEPTH = 3072;
  localparam int MAXB  = 8;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  logic        clk, reset;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m0_pc, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, dm_wr;
  logic [31:0] m0_rdata, m1_rdata, dm_addr, dm_wd, dm_pc, dm_rdata;

  dm_access_arbiter #(.DEPTH_WORDS(DEPTH), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_pc(m0_pc),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_err(m0_err), .m1_err(m1_err),
    .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_pc(dm_pc), .dm_rdata(dm_rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory environment ----------------
  bit [31:0] mem [4096];
  always_comb begin
    dm_rdata = 32'hBAD0_BAD0;
    if (dm_addr < LIMIT) dm_rdata = mem[dm_addr[13:2]];
  end
  always @(posedge clk) if (dm_wr && (dm_addr < LIMIT)) mem[dm_addr[13:2]] <= dm_wd;

  // ---------------- scoreboard / model ----------------
  bit [31:0]   exp_mem [4096];
  logic [31:0] exp_q [$];
  int n_cmp, n_bad;
  int md_last, md_run;
  bit md_locked;

  logic o_g0, o_g1, o_wr, o_v0, o_e0, o_v1, o_e1;
  logic [31:0] o_addr, o_wd, o_pc, o_r0, o_r1;
  logic e_g0, e_g1, e_wr, e_v0, e_e0, e_v1, e_e1;
  logic [31:0] e_addr, e_wd, e_pc, e_r0, e_r1;

  // ---------------- drivers ----------------
  task automatic set_m0(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] pc);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; m0_pc = pc;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic lock);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_lock = lock;
  endtask

  task automatic idle();
    set_m0(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // One clock: sample combinational outputs, advance the model, cross the edge,
  // sample registered outputs. Called at posedge+1 with inputs already applied.
  task automatic tick();
    logic [31:0] a, wd, rd;
    logic we, legal;
    int w;
    #3;
    o_g0 = m0_gnt; o_g1 = m1_gnt; o_wr = dm_wr;
    o_addr = dm_addr; o_wd = dm_wd; o_pc = dm_pc;
    w = 0;
    if (!reset) begin
      if (md_last == 1 && md_locked && m1_req && (md_run < MAXB || !m0_req)) w = 2;
      else if (m0_req && m1_req) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
        w = (md_last == 1) ? 1 : 2;
`else
        w = 1;
`endif
      end else if (m0_req) w = 1;
      else if (m1_req) w = 2;
    end
    a  = (w == 2) ? m1_addr  : m0_addr;
    wd = (w == 2) ? m1_wdata : m0_wdata;
    we = (w == 2) ? m1_we    : m0_we;
    legal = (a[1:0] == 2'b00) && (a < LIMIT);
    e_g0 = (w == 1); e_g1 = (w == 2);
    e_addr = a; e_wd = wd; e_pc = (w == 1) ? m0_pc : 32'h0;
    e_wr = (w != 0) && we && legal;
    if (w != 0) exp_q.push_back((!we && legal) ? exp_mem[a[13:2]] : 32'h0);
    if (e_wr) exp_mem[a[13:2]] = wd;
    if (reset) begin
      md_last = 1; md_run = 0; md_locked = 0;
    end else begin
      if (w == 2) begin
        if (m1_lock && md_run < 255) md_run++;
      end else md_run = 0;
      md_locked = (w == 2) && m1_lock;
      if (w != 0) md_last = w - 1;
    end
    rd = (w != 0) ? exp_q.pop_front() : 32'h0;
    e_v0 = (w == 1); e_e0 = (w == 1) && !legal; e_r0 = (w == 1) ? rd : 32'h0;
    e_v1 = (w == 2); e_e1 = (w == 2) && !legal; e_r1 = (w == 2) ? rd : 32'h0;
    @(posedge clk); #1;
    o_v0 = m0_rvalid; o_e0 = m0_err; o_r0 = m0_rdata;
    o_v1 = m1_rvalid; o_e1 = m1_err; o_r1 = m1_rdata;
  endtask

  task automatic reset_cycle();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 32'($urandom_range(0, 31)) << 2;
    else if (r == 7) return (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(1, 3));
    else if (r == 8) return 32'h3000 + (32'($urandom_range(0, 15)) << 2);
    else             return 32'hFFFF_FFFC;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    set_m0(1'b1, 1'b1, 32'h20, 32'h1234_5678, 32'h100);
    set_m1(1'b1, 1'b1, 32'h24, 32'h8765_4321, 1'b1);
    tick();
    n_cmp++; if ({o_g0, o_g1, o_wr} !== 3'b000) begin n_bad++; $display("FAIL rst_gnt: got g0g1wr=%b want 000", {o_g0, o_g1, o_wr}); end
    n_cmp++; if ({o_v0, o_e0, o_r0, o_v1, o_e1, o_r1} !== 68'h0) begin n_bad++; $display("FAIL rst_regs: got v0=%b e0=%b r0=%h v1=%b e1=%b r1=%h want all 0", o_v0, o_e0, o_r0, o_v1, o_e1, o_r1); end
    reset = 1'b0; idle(); tick();
    n_cmp++; if ({o_v0, o_v1, o_g0, o_g1} !== 4'b0000) begin n_bad++; $display("FAIL rst_idle: got v0v1g0g1=%b want 0000", {o_v0, o_v1, o_g0, o_g1}); end
  endtask

  task automatic test_write_read();
    idle(); set_m0(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h400); tick();
    n_cmp++; if ({o_g0, o_g1, o_wr} !== 3'b101) begin n_bad++; $display("FAIL wr_gnt: got g0g1wr=%b want 101", {o_g0, o_g1, o_wr}); end
    n_cmp++; if ({o_addr, o_wd, o_pc} !== {32'h10, 32'hDEAD_BEEF, 32'h400}) begin n_bad++; $display("FAIL wr_bus: got addr=%h wd=%h pc=%h want 10 deadbeef 400", o_addr, o_wd, o_pc); end
    n_cmp++; if ({o_v0, o_e0} !== 2'b10) begin n_bad++; $display("FAIL wr_resp: got rvalid/err=%b want 10", {o_v0, o_e0}); end
    set_m0(1'b1, 1'b0, 32'h10, 32'h0, 32'h404); tick();
    n_cmp++; if ({o_g0, o_wr, o_v0, o_e0, o_r0} !== {4'b1010, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL rd_data: got g0=%b wr=%b v=%b e=%b rdata=%h want 1 0 1 0 deadbeef", o_g0, o_wr, o_v0, o_e0, o_r0); end
    idle(); tick();
    n_cmp++; if (o_v0 !== 1'b0) begin n_bad++; $display("FAIL rd_single: got rvalid=%b want 0", o_v0); end
  endtask

  task automatic test_illegal();
    idle(); set_m0(1'b1, 1'b1, 32'h4, 32'hCAFE_F00D, 32'h0); tick();
    idle(); set_m1(1'b1, 1'b1, 32'h3000, 32'h1111_1111, 1'b0); tick();
    n_cmp++; if ({o_g1, o_wr} !== 2'b10) begin n_bad++; $display("FAIL oor_gnt: got g1/wr=%b want 10", {o_g1, o_wr}); end
    n_cmp++; if ({o_v1, o_e1, o_r1} !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL oor_resp: got v=%b e=%b r=%h want 1 1 0", o_v1, o_e1, o_r1); end
    idle(); set_m0(1'b1, 1'b1, 32'h6, 32'h2222_2222, 32'h0); tick();
    n_cmp++; if ({o_g0, o_wr} !== 2'b10) begin n_bad++; $display("FAIL mis_gnt: got g0/wr=%b want 10", {o_g0, o_wr}); end
    n_cmp++; if ({o_v0, o_e0, o_r0} !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL mis_resp: got v=%b e=%b r=%h want 1 1 0", o_v0, o_e0, o_r0); end
    idle(); set_m1(1'b1, 1'b0, 32'h3000, 32'h0, 1'b0); tick();
    n_cmp++; if ({o_v1, o_e1, o_r1} !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL oor_rd: got v=%b e=%b r=%h want 1 1 0", o_v1, o_e1, o_r1); end
    idle(); set_m0(1'b1, 1'b0, 32'h4, 32'h0, 32'h0); tick();
    n_cmp++; if ({o_e0, o_r0} !== {1'b0, 32'hCAFE_F00D}) begin n_bad++; $display("FAIL mem_kept: got e=%b r=%h want 0 cafef00d", o_e0, o_r0); end
  endtask

  task automatic test_arbitration();
    logic want0;
    idle(); reset_cycle();
    set_m0(1'b1, 1'b0, 32'h20, 32'h0, 32'h200);
    set_m1(1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
      want0 = (i % 2 == 0);
`else
      want0 = 1'b1;
`endif
      tick();
      n_cmp++; if ({o_g0, o_g1} !== {want0, !want0}) begin n_bad++; $display("FAIL arb_%0d: got g0g1=%b want %b", i, {o_g0, o_g1}, {want0, !want0}); end
      n_cmp++; if ({o_v0, o_v1} !== {want0, !want0}) begin n_bad++; $display("FAIL arb_lag_%0d: got v0v1=%b want %b", i, {o_v0, o_v1}, {want0, !want0}); end
    end
  endtask

  task automatic test_burst();
    int n1;
    idle(); reset_cycle();
    for (int round = 0; round < 2; round++) begin
      set_m1(1'b1, 1'b0, 32'h40, 32'h0, 1'b1); m0_req = 1'b0; tick();
      n1 = o_g1 ? 1 : 0;
      set_m0(1'b1, 1'b0, 32'h44, 32'h0, 32'h300);
      for (int k = 0; k < 20; k++) begin
        tick();
        if (o_g1) n1++; else break;
      end
      n_cmp++; if (n1 !== MAXB) begin n_bad++; $display("FAIL burst_len_%0d: got %0d M1 grants want %0d", round, n1, MAXB); end
      n_cmp++; if ({o_g0, o_g1} !== 2'b10) begin n_bad++; $display("FAIL burst_release_%0d: got g0g1=%b want 10", round, {o_g0, o_g1}); end
    end
  endtask

  task automatic test_reset_midburst();
    idle(); reset_cycle();
    set_m1(1'b1, 1'b1, 32'h80, 32'h5555_AAAA, 1'b1); tick();
    set_m0(1'b1, 1'b0, 32'h84, 32'h0, 32'h500);
    for (int k = 0; k < 4; k++) tick();
    n_cmp++; if (o_g1 !== 1'b1) begin n_bad++; $display("FAIL mid_pre: got g1=%b want 1", o_g1); end
    reset = 1'b1; tick();
    n_cmp++; if ({o_g0, o_g1, o_wr} !== 3'b000) begin n_bad++; $display("FAIL mid_rst_gnt: got g0g1wr=%b want 000", {o_g0, o_g1, o_wr}); end
    n_cmp++; if ({o_v0, o_e0, o_r0, o_v1, o_e1, o_r1} !== 68'h0) begin n_bad++; $display("FAIL mid_rst_regs: got v0=%b e0=%b r0=%h v1=%b e1=%b r1=%h want all 0", o_v0, o_e0, o_r0, o_v1, o_e1, o_r1); end
    reset = 1'b0; tick();
    n_cmp++; if ({o_g0, o_g1} !== 2'b10) begin n_bad++; $display("FAIL mid_after: got g0g1=%b want 10", {o_g0, o_g1}); end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 0; i < 3; i++) begin
      set_m0(1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'h0101_0101 * 32'(i) + 32'h5, 32'h0); tick();
      n_cmp++; if ({o_g0, o_v0, o_e0} !== 3'b110) begin n_bad++; $display("FAIL b2b_wr_%0d: got g/v/e=%b want 110", i, {o_g0, o_v0, o_e0}); end
    end
    for (int i = 0; i < 3; i++) begin
      set_m0(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 32'h0); tick();
      n_cmp++; if ({o_v0, o_r0} !== {1'b1, 32'h0101_0101 * 32'(i) + 32'h5}) begin n_bad++; $display("FAIL b2b_rd_%0d: got v=%b r=%h want 1 %h", i, o_v0, o_r0, 32'h0101_0101 * 32'(i) + 32'h5); end
    end
    idle(); tick();
  endtask

  task automatic test_random();
    idle(); tick();
    for (int i = 0; i < 400; i++) begin
      if (!(m0_req && !e_g0))
        set_m0($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), rand_addr(), $urandom(), $urandom());
      if (!(m1_req && !e_g1))
        set_m1($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), rand_addr(), $urandom(), $urandom_range(0, 9) < 7);
      tick();
      n_cmp++; if ({o_g0, o_g1, o_wr} !== {e_g0, e_g1, e_wr}) begin n_bad++; $display("FAIL rnd_gnt_%0d: got g0g1wr=%b want %b", i, {o_g0, o_g1, o_wr}, {e_g0, e_g1, e_wr}); end
      n_cmp++; if ({o_addr, o_wd} !== {e_addr, e_wd}) begin n_bad++; $display("FAIL rnd_bus_%0d: got addr=%h wd=%h want %h %h", i, o_addr, o_wd, e_addr, e_wd); end
      if (e_g0 || e_g1) begin
        n_cmp++; if (o_pc !== e_pc) begin n_bad++; $display("FAIL rnd_pc_%0d: got %h want %h", i, o_pc, e_pc); end
      end
      n_cmp++; if ({o_v0, o_e0, o_r0, o_v1, o_e1, o_r1} !== {e_v0, e_e0, e_r0, e_v1, e_e1, e_r1}) begin n_bad++; $display("FAIL rnd_resp_%0d: got v0=%b e0=%b r0=%h v1=%b e1=%b r1=%h want %b %b %h %b %b %h", i, o_v0, o_e0, o_r0, o_v1, o_e1, o_r1, e_v0, e_e0, e_r0, e_v1, e_e1, e_r1); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0; n_bad = 0;
    md_last = 1; md_run = 0; md_locked = 1'b0;
    e_g0 = 1'b0; e_g1 = 1'b0;
    reset = 1'b1; idle();
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_illegal();
    test_arbitration();
    test_burst();
    test_reset_midburst();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dm_access_arbiter.md
# dm_access_arbiter

Shares the single-port data memory between two requesters: M0, the pipeline MEM stage, and M1, a bulk-copy/DMA engine. Each cycle it picks at most one winner, drives the memory's write-enable, address, write-data and PC lines from that winner, and returns registered read data one cycle later. It also bounds M1 burst locks so M0 cannot starve, and rejects misaligned or out-of-range accesses before they reach memory.

## Interface
Parameters:
- DEPTH_WORDS, 3072: memory depth in 32-bit words. Legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- MAX_BURST, 8: maximum consecutive locked M1 grants while M0 is waiting. Range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m0_req / m1_req  in  1  access request, sampled every cycle.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_pc  in  32  PC of the M0 instruction, forwarded for the write log.
- m1_lock  in  1  M1 asks to keep the grant on its next request.
- m0_gnt / m1_gnt  out  1  combinational grant, same cycle as the request.
- m0_rvalid / m1_rvalid  out  1  registered; high the cycle after a grant.
- m0_rdata / m1_rdata  out  32  registered read data.
- m0_err / m1_err  out  1  registered; qualifies rvalid for a rejected access.
- dm_wr  out  1  memory write enable.
- dm_addr  out  32  memory byte address.
- dm_wd  out  32  memory write data.
- dm_pc  out  32  PC passed to memory. Carries m0_pc when M0 wins and 32'h0 when M1 wins.
- dm_rdata  in  32  combinational read data from memory at dm_addr.

## Operation
State registers:
- last_gnt (1 bit; 0 = M0, 1 = M1). Reset value 1.
- burst_cnt (8 bits). Reset value 0.
- rvalid, rdata and err registers for both ports. Reset value 0.

Arbitration, evaluated combinationally each cycle:
1. During reset: no grant, dm_wr = 0.
2. Lock hold: M1 keeps the grant when all of these hold:
   - last_gnt = 1
   - M1 was granted in the previous cycle
   - m1_lock was high in that previous cycle
   - m1_req is high now
   - either burst_cnt < MAX_BURST, or m0_req = 0
3. Otherwise, if only one master requests, that master wins.
4. Otherwise, if both request, the policy set by ROUND_ROBIN_EN decides (see Configuration).
5. Otherwise, no grant.

Per-grant actions:
- Legality: an access is legal when addr[1:0] == 0 and addr < 4*DEPTH_WORDS.
- dm_addr and dm_wd always follow the winner. With no winner they follow M0.
- dm_wr = granted & we & legal.
- Next cycle, the winner's rvalid = 1 and err = !legal. rdata = dm_rdata for a legal read, and 0 otherwise (writes and illegal accesses).
- burst_cnt increments (saturating at 255) on each M1 grant with m1_lock high. It clears to 0 on any cycle M1 is not granted.
- last_gnt updates to the winner. It holds when there is no grant.

## Timing
- Grant and memory drive take zero cycles (combinational). Memory writes commit at the granting clock edge.
- Read latency is 1 cycle: rvalid, rdata and err are valid the cycle after gnt, for exactly one cycle per grant.
- A master that is not granted must hold req and its payload stable until granted.
- Back-to-back grants to the same master give back-to-back rvalid pulses.
- The rvalid of a grant issued in the reset cycle is not produced: reset clears all registers, and gnt is 0 during reset anyway.
- Forced release: after MAX_BURST locked M1 grants with m0_req high, M0 wins the next cycle. M1 can lock again afterwards, with burst_cnt restarting from 0.

## Configuration
- DM_ARB_ROUND_ROBIN_EN defined: when both masters request, the winner is !last_gnt (alternation).
- DM_ARB_ROUND_ROBIN_EN undefined: when both masters request, M0 always wins (fixed priority). Lock hold and forced release still apply unchanged.

## Test plan
- Reset, then m0_req=1, we=1, addr=0x10, wdata=0xDEADBEEF → m0_gnt=1, dm_wr=1, dm_addr=0x10. Next cycle m0_rvalid=1, m0_err=0. A read of 0x10 then returns m0_rdata=0xDEADBEEF one cycle after its grant.
- Both request reads every cycle with round-robin enabled, starting from reset → grants go M0, M1, M0, M1. Each rvalid lags its grant by 1 cycle.
- m1_lock=1 with m1_req and m0_req held high, MAX_BURST=8 → M1 granted 8 consecutive cycles, M0 granted on the 9th, then M1 again with burst_cnt=1.
- M1 write to addr=0x3000 (out of range) and M0 write to addr=0x6 (misaligned) → gnt=1, dm_wr=0, and next cycle err=1, rvalid=1, rdata=0. Memory contents unchanged.
- Without DM_ARB_ROUND_ROBIN_EN, both requesting for 5 cycles with m1_lock=0 → M0 granted all 5 cycles, M1 never granted.
- Assert reset mid-burst (burst_cnt=5) → same cycle dm_wr=0 and both gnt=0. Next cycle rvalid, err and rdata are all 0, burst_cnt=0, last_gnt=1.
